// File: rtl/xc_rf_banked.sv
// Odd/even banked register file with two write ports, NRP combinational read ports
// and a multi-cycle zeroisation engine. Define XC_RF_BYPASS_EN to forward same-cycle writes to reads.
module xc_rf_banked #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRP   = 3,
  parameter int unsigned AW    = 5
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_rdata,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_wdata,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_wdata,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  localparam int unsigned NENT = NREGS / 2;
  localparam int unsigned IW   = AW - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   clr_idx_q, clr_idx_d;
  logic            clr_busy_q, clr_busy_d;
  logic            clr_done_q, clr_done_d;
  logic [XLEN-1:0] even_q [NENT];
  logic [XLEN-1:0] even_d [NENT];
  logic [XLEN-1:0] odd_q  [NENT];
  logic [XLEN-1:0] odd_d  [NENT];

  logic busy_c;
  logic wa_ok_c;
  logic wb_ok_c;

  assign busy_c  = (state_q != ST_IDLE);
  assign wa_ok_c = wa_en && (wa_addr != '0) && !busy_c;
  assign wb_ok_c = wb_en && (wb_addr != '0) && !busy_c;

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

  // Zeroisation sequencer: one even/odd entry pair per CLEAR cycle.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_busy_d = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + IW'(1);
        if (clr_idx_q == IW'(NENT - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    clr_busy_d = (state_d != ST_IDLE);
    clr_done_d = (state_d == ST_DONE);
  end

  // Bank update; port B is applied last so it wins an address collision.
  always_comb begin
    even_d = even_q;
    odd_d  = odd_q;
    if (state_q == ST_CLEAR) begin
      even_d[clr_idx_q] = '0;
      odd_d[clr_idx_q]  = '0;
    end else begin
      if (wa_ok_c) begin
        if (wa_addr[0]) begin
          odd_d[wa_addr[AW-1:1]] = wa_wdata;
        end else begin
          even_d[wa_addr[AW-1:1]] = wa_wdata;
        end
      end
      if (wb_ok_c) begin
        if (wb_addr[0]) begin
          odd_d[wb_addr[AW-1:1]] = wb_wdata;
        end else begin
          even_d[wb_addr[AW-1:1]] = wb_wdata;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      clr_idx_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      for (int unsigned i = 0; i < NENT; i++) begin
        even_q[i] <= '0;
        odd_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
    end
  end

  // Read ports; entry 0 of the even bank is architectural x0 and is masked.
  always_comb begin : read_ports
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;
    rs_rdata = '0;
    for (int unsigned k = 0; k < NRP; k++) begin
      ra = rs_addr[k*AW +: AW];
      if (ra[0]) begin
        rv = odd_q[ra[AW-1:1]];
      end else begin
        rv = even_q[ra[AW-1:1]];
      end
`ifdef XC_RF_BYPASS_EN
      if (wb_ok_c && (wb_addr == ra)) begin
        rv = wb_wdata;
      end else if (wa_ok_c && (wa_addr == ra)) begin
        rv = wa_wdata;
      end
`endif
      if (ra == '0) begin
        rv = '0;
      end
      rs_rdata[k*XLEN +: XLEN] = rv;
    end
  end

endmodule
